// File: rtl/bit_parse_pkg.sv
// bit_parse shared definitions.
// Widths, state encoding and fill-count sizing for the VDC-M bit reader.
package bit_parse_pkg;

    localparam int WORD_W = 128;
    localparam int BUF_W  = 2 * WORD_W;
    localparam int MAX_LEN = 32;
    localparam int FILL_W = 9;
    localparam int LEN_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A field length is usable only in 1..MAX_LEN; 0 means "no request".
    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(MAX_LEN));
    endfunction

endpackage

// File: rtl/bit_parse_extract.sv
// bit_extract: next-state network for the MSB-first bit buffer.
// Drops a consumed field off the top and splices a fresh word below the kept bits.
module bit_extract
    import bit_parse_pkg::*;
(
    input  logic [BUF_W-1:0]  i_buf,
    input  logic [FILL_W-1:0] i_fill,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_consume,
    input  logic              i_refill,
    input  logic [WORD_W-1:0] i_word,
    output logic [BUF_W-1:0]  o_buf,
    output logic [FILL_W-1:0] o_fill
);

    logic [FILL_W-1:0] w_shift;
    logic [FILL_W-1:0] w_keep;
    logic [BUF_W-1:0]  w_shifted;
    logic [BUF_W-1:0]  w_mask;
    logic [BUF_W-1:0]  w_ins;

    // Shift out the field, keep only valid bits, then land the new word just below them.
    always_comb begin
        w_shift   = '0;
        w_keep    = '0;
        w_shifted = '0;
        w_mask    = '0;
        w_ins     = '0;
        o_buf     = i_buf;
        o_fill    = i_fill;

        w_shift   = i_consume ? FILL_W'(i_len) : '0;
        w_keep    = i_fill - w_shift;
        w_shifted = i_buf << w_shift;
        // Ones over the top w_keep bits; a shift of BUF_W yields an all-ones mask.
        w_mask    = ~({BUF_W{1'b1}} >> w_keep);
        w_ins     = {i_word, {(BUF_W - WORD_W){1'b0}}} >> w_keep;

        o_buf  = (w_shifted & w_mask) | (i_refill ? w_ins : '0);
        o_fill = w_keep + (i_refill ? FILL_W'(WORD_W) : '0);
    end

endmodule

// File: rtl/bit_parse.sv
// bit_parse: front-end bit reader of the VDC-M decoder.
// Prefetches 128-bit words into a 256-bit buffer and peeks/consumes 1..32-bit fields.
module bit_parse
    import bit_parse_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_dec,
    output logic              codec_data_rd_en,
    input  logic [WORD_W-1:0] codec_data,
    input  logic              bits_req,
    input  logic [LEN_W-1:0]  bits_len,
    output logic [MAX_LEN-1:0] bits_data,
    output logic              bits_ready,
    output logic [FILL_W-1:0] bits_avail,
    output logic              busy
);

    state_t r_state;
    state_t w_state_next;

    logic [BUF_W-1:0]  r_buf;
    logic [FILL_W-1:0] r_fill;
    logic [BUF_W-1:0]  w_buf_next;
    logic [FILL_W-1:0] w_fill_next;

    logic               w_run;
    logic               w_ready;
    logic               w_refill;
    logic               w_consume;
    logic [MAX_LEN-1:0] w_top;
    logic [LEN_W-1:0]   w_rsh;

    assign w_run     = (r_state == RUN);
    assign w_ready   = w_run && len_legal(bits_len)
                       && (FILL_W'(bits_len) <= r_fill);
    // Refill whenever a whole word fits; this is what keeps the buffer from overflowing.
    assign w_refill  = w_run && (r_fill <= FILL_W'(WORD_W));
    assign w_consume = bits_req && w_ready;

    // Peek: top MAX_LEN bits, right-aligned to the requested length.
    assign w_top = r_buf[BUF_W-1 -: MAX_LEN];
    assign w_rsh = LEN_W'(MAX_LEN) - bits_len;

    assign bits_data        = w_ready ? (w_top >> w_rsh) : '0;
    assign bits_ready       = w_ready;
    assign codec_data_rd_en = w_refill;
    assign bits_avail       = r_fill;
    assign busy             = w_run;

    bit_extract u_extract (
        .i_buf     (r_buf),
        .i_fill    (r_fill),
        .i_len     (bits_len),
        .i_consume (w_consume),
        .i_refill  (w_refill),
        .i_word    (codec_data),
        .o_buf     (w_buf_next),
        .o_fill    (w_fill_next)
    );

    // Next-state: start once from IDLE, then run until reset.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (start_dec) w_state_next = RUN;
            RUN:  w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bit buffer and fill count; only move while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else if (w_run) begin
            r_buf  <= w_buf_next;
            r_fill <= w_fill_next;
        end
    end

endmodule

// File: tb/tb_bit_parse.sv
// Bench for bit_parse: bit-stream reference model plus scoreboard.
// Expected fields come from the source words read as one flat bit string.
module tb_bit_parse;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_dec = 1'b0;
    logic         bits_req = 1'b0;
    logic [5:0]   bits_len = '0;
    logic         codec_data_rd_en;
    logic [127:0] codec_data;
    logic [31:0]  bits_data;
    logic         bits_ready;
    logic [8:0]   bits_avail;
    logic         busy;

    logic [127:0] words [64];
    int  src_idx = 0;
    int  pops = 0;
    int  cursor = 0;
    bit  running = 0;
    bit  smp_pop = 0;
    bit  smp_acc = 0;
    bit  smp_start = 0;
    int  smp_len = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];

    always #5 clk = ~clk;

    assign codec_data = words[src_idx[5:0]];

    bit_parse dut (
        .clk              (clk),
        .rst              (rst),
        .start_dec        (start_dec),
        .codec_data_rd_en (codec_data_rd_en),
        .codec_data       (codec_data),
        .bits_req         (bits_req),
        .bits_len         (bits_len),
        .bits_data        (bits_data),
        .bits_ready       (bits_ready),
        .bits_avail       (bits_avail),
        .busy             (busy)
    );

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Bits [pos .. pos+len-1] of the concatenated source words.
    function automatic logic [31:0] stream_field(input int pos, input int len);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < len; k++) begin
            int b;
            b = pos + k;
            v = (v << 1) | 32'(words[b / 128][127 - (b % 128)]);
        end
        return v;
    endfunction

    // Monitor: sample between edges, compare to the model, pop the scoreboard.
    always @(negedge clk) begin
        int fm;
        logic [31:0] e;
        #3;
        smp_pop   = codec_data_rd_en;
        smp_acc   = bits_req && bits_ready;
        smp_len   = int'(bits_len);
        smp_start = start_dec && !running;
        fm = running ? (128 * pops - cursor) : 0;
        check("busy", busy, running);
        check("avail", bits_avail, fm);
        check("rd_en", codec_data_rd_en, running && fm <= 128);
        check("ready", bits_ready,
              running && bits_len != 0 && bits_len <= 32 && fm >= int'(bits_len));
        if (bits_req && bits_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_accept: got %0h expected none", bits_data);
            end else begin
                e = exp_q.pop_front();
                check("field", bits_data, e);
                got_q.push_back(bits_data);
            end
        end else if (!bits_ready) begin
            check("data_not_ready", bits_data, 0);
        end
    end

    // Model update just after each edge, from the values sampled before it.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (smp_pop) begin
                pops++;
                src_idx++;
            end
            if (smp_acc) cursor += smp_len;
            if (smp_start) running = 1;
        end
        smp_pop = 0;
        smp_acc = 0;
        smp_start = 0;
    end

    task automatic randomize_words();
        for (int i = 0; i < 64; i++)
            words[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_dec = 1'b1;
        @(negedge clk);
        start_dec = 1'b0;
    endtask

    // Issue one field and hold it until accepted; called at a falling edge.
    task automatic do_field(input int len, output int waits);
        bit ok;
        ok = 0;
        waits = 0;
        bits_req = 1'b1;
        bits_len = 6'(len);
        exp_q.push_back(stream_field(cursor, len));
        for (int i = 0; i < 40; i++) begin
            #3;
            if (bits_ready) ok = 1;
            @(negedge clk);
            if (ok) break;
            waits++;
        end
        bits_req = 1'b0;
        bits_len = '0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept len %0d", len);
            exp_q.delete();
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
    task automatic reset_dut();
        @(negedge clk);
        #4;
        rst = 1'b1;
        running = 0;
        pops = 0;
        cursor = 0;
        src_idx = 0;
        smp_pop = 0;
        smp_acc = 0;
        smp_start = 0;
        exp_q.delete();
        got_q.delete();
        #0.5;
        check("rst_rd_en", codec_data_rd_en, 0);
        check("rst_ready", bits_ready, 0);
        check("rst_data", bits_data, 0);
        check("rst_avail", bits_avail, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int w;
        int gaps;
        int p0;
        for (int i = 0; i < 64; i++) words[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle with start low: nothing moves.
        idle(10);
        check("idle_pops", pops, 0);
        check("idle_busy", busy, 0);

        // Known first word.
        randomize_words();
        words[0] = 128'h0123456789ABCDEF_FEDCBA9876543210;
        pulse_start();
        do_field(8, w);
        do_field(4, w);
        do_field(32, w);
        check("known_len8", got_q[0], 32'h01);
        check("known_len4", got_q[1], 32'h2);
        check("known_len32", got_q[2], 32'h3456789A);
        check("known_avail", bits_avail, 212);
        check("known_pops", pops, 2);

        // Zero-length request is a no-op.
        bits_req = 1'b1;
        bits_len = '0;
        idle(3);
        bits_req = 1'b0;
        check("len0_avail", bits_avail, 212);
        check("len0_cursor", cursor, 44);

        // Reset mid-stream at fill 150, then restart.
        reset_dut();
        randomize_words();
        pulse_start();
        do_field(32, w);
        do_field(32, w);
        do_field(32, w);
        do_field(10, w);
        check("fill150", bits_avail, 150);
        reset_dut();

        // Back-to-back 32-bit fields over 21 words.
        randomize_words();
        pulse_start();
        gaps = 0;
        p0 = 0;
        for (int i = 0; i < 84; i++) begin
            do_field(32, w);
            if (i > 0) gaps += w;
            if (i == 7) p0 = pops;
        end
        check("stream_gaps", gaps, 0);
        check("pops_per_4", pops - p0, 19);
        check("stream_count", got_q.size(), 84);

        // Field straddling the word0/word1 boundary.
        reset_dut();
        randomize_words();
        pulse_start();
        do_field(32, w);
        do_field(32, w);
        do_field(32, w);
        do_field(24, w);
        do_field(16, w);
        check("straddle", got_q[4], {16'h0, words[0][7:0], words[1][127:120]});

        // Random lengths with idle and zero-length cycles.
        reset_dut();
        randomize_words();
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                idle(1);
            end else if (r == 1) begin
                bits_req = 1'b1;
                bits_len = '0;
                @(negedge clk);
                bits_req = 1'b0;
            end
            do_field(int'($urandom_range(1, 32)), w);
        end
        check("random_count", got_q.size(), 200);
        check("random_drained", exp_q.size(), 0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
